// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e    : frame FSM states
//   PS2_BREAK/EXT  : prefix scan codes
//   PS2_FRAME_BITS : start + 8 data + parity + stop
//   odd_parity_ok  : true when data plus parity holds an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser and glitch filter for the raw PS/2 clock pin.
//   clock, reset : system clock, async active-high reset
//   raw          : asynchronous pin
//   fall         : one-cycle pulse when the filtered level goes 1->0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic fall
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic          filt;
  logic          filt_q;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synced samples disagree with filt;
  // any agreeing sample restarts the run, so short glitches never flip filt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync   <= 2'b11;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      cnt    <= '0;
    end else begin
      sync   <= {sync[0], raw};
      filt_q <= filt;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames device-to-host bytes, folds F0/E0 prefixes
// into a single key event strobe, and flags bad or stalled frames.
//   clock, reset   : system clock, async active-high reset
//   kb_clk/kb_data : raw PS/2 pins
//   key_code       : scan code of last event (held between strobes)
//   key_valid      : one-cycle event strobe
//   key_release    : event carried an F0 prefix
//   key_extended   : event carried an E0 prefix
//   frame_err      : one-cycle strobe on parity/stop/timeout error
//   busy           : frame FSM not idle
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling edge)
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, then decoding the byte
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    DATA_LAST = 3'(PS2_FRAME_BITS - 4);

  ps2_state_e    state;
  logic [1:0]    data_sync;
  logic          data_s;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          pend_rel;
  logic          pend_ext;
  logic [TW-1:0] to_cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock (clock),
    .reset (reset),
    .raw   (kb_clk),
    .fall  (fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_sync <= 2'b11;
    end else begin
      data_sync <= {data_sync[0], kb_data};
    end
  end

  assign data_s = data_sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      pend_rel     <= 1'b0;
      pend_ext     <= 1'b0;
      to_cnt       <= '0;
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        // An edge always restarts the stall timer, even on its terminal cycle.
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift <= {data_s, shift[7:1]};
            if (bit_cnt == DATA_LAST) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s && odd_parity_ok(shift, par_bit)) begin
              if (shift == PS2_BREAK) begin
                pend_rel <= 1'b1;
              end else if (shift == PS2_EXT) begin
                pend_ext <= 1'b1;
              end else begin
                key_valid    <= 1'b1;
                key_code     <= shift;
                key_release  <= pend_rel;
                key_extended <= pend_ext;
                pend_rel     <= 1'b0;
                pend_ext     <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              pend_rel  <= 1'b0;
              pend_ext  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_LAST) begin
          state     <= IDLE;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          pend_rel  <= 1'b0;
          pend_ext  <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

  localparam int HP      = 20;    // PS/2 half bit period in system clocks
  localparam int TIMEOUT = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_extended;
  logic       frame_err;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int kv0, fe0;

  ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .kb_clk       (kb_clk),
    .kb_data      (kb_data),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_release  (key_release),
    .key_extended (key_extended),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mark();
    kv0 = kv_cnt;
    fe0 = fe_cnt;
  endtask

  // Sends the first nbits of bits (LSB first); glitch_bit >= 0 drops kb_clk
  // for 3 cycles in the middle of that bit's high phase.
  task automatic send_raw(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      kb_data = bits[i];
      if (i == glitch_bit) begin
        tick(HP / 2);
        kb_clk = 1'b0;
        tick(3);
        kb_clk = 1'b1;
        tick(HP - HP / 2 - 3);
      end else begin
        tick(HP);
      end
      kb_clk = 1'b0;
      tick(HP);
      kb_clk = 1'b1;
    end
    tick(HP);
    kb_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_bit);
    logic par;
    par = (~^b) ^ bad_par;
    send_raw({1'b1, par, b, 1'b0}, 11, glitch_bit);
    tick(2 * HP);
  endtask

  initial begin
    tick(3);
    check("rst_code", key_code, 8'h00);
    check("rst_valid", key_valid, 1'b0);
    check("rst_rel", key_release, 1'b0);
    check("rst_ext", key_extended, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(20);

    // plain make code
    mark();
    send_frame(8'h1C, 1'b0, -1);
    check("make_cnt", kv_cnt - kv0, 1);
    check("make_code", key_code, 8'h1C);
    check("make_rel", key_release, 1'b0);
    check("make_ext", key_extended, 1'b0);
    check("make_err", fe_cnt - fe0, 0);

    // break
    mark();
    send_frame(8'hF0, 1'b0, -1);
    check("brk_prefix_cnt", kv_cnt - kv0, 0);
    send_frame(8'h1C, 1'b0, -1);
    check("brk_cnt", kv_cnt - kv0, 1);
    check("brk_code", key_code, 8'h1C);
    check("brk_rel", key_release, 1'b1);
    check("brk_ext", key_extended, 1'b0);

    // extended break then plain make
    mark();
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    check("ext_cnt", kv_cnt - kv0, 1);
    check("ext_code", key_code, 8'h75);
    check("ext_rel", key_release, 1'b1);
    check("ext_ext", key_extended, 1'b1);
    send_frame(8'h1C, 1'b0, -1);
    check("after_ext_code", key_code, 8'h1C);
    check("after_ext_rel", key_release, 1'b0);
    check("after_ext_ext", key_extended, 1'b0);

    // bad parity: error strobe, outputs hold, pending prefix dropped
    send_frame(8'h75, 1'b0, -1);
    mark();
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h1C, 1'b1, -1);
    check("par_err_cnt", fe_cnt - fe0, 1);
    check("par_kv_cnt", kv_cnt - kv0, 0);
    check("par_hold_code", key_code, 8'h75);
    send_frame(8'h1C, 1'b0, -1);
    check("par_next_code", key_code, 8'h1C);
    check("par_orphan_rel", key_release, 1'b0);

    // bad stop bit
    mark();
    send_raw({1'b0, ~^8'h29, 8'h29, 1'b0}, 11, -1);
    tick(2 * HP);
    check("stop_err_cnt", fe_cnt - fe0, 1);
    check("stop_kv_cnt", kv_cnt - kv0, 0);

    // stalled frame after an E0 prefix
    mark();
    send_frame(8'hE0, 1'b0, -1);
    send_raw(11'b000_0101_1010, 5, -1);
    check("to_busy", busy, 1'b1);
    tick(TIMEOUT + 500);
    check("to_idle", busy, 1'b0);
    check("to_err_cnt", fe_cnt - fe0, 1);
    send_frame(8'h32, 1'b0, -1);
    check("to_kv_cnt", kv_cnt - kv0, 1);
    check("to_code", key_code, 8'h32);
    check("to_ext_dropped", key_extended, 1'b0);

    // short glitch on kb_clk must not add a bit
    mark();
    send_frame(8'h5A, 1'b0, 4);
    check("gl_kv_cnt", kv_cnt - kv0, 1);
    check("gl_code", key_code, 8'h5A);
    check("gl_err_cnt", fe_cnt - fe0, 0);

    // reset in the middle of a frame
    mark();
    send_raw(11'b000_0000_1110, 4, -1);
    check("mr_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mr_code", key_code, 8'h00);
    check("mr_busy0", busy, 1'b0);
    check("mr_valid", key_valid, 1'b0);
    check("mr_err", frame_err, 1'b0);
    tick(5);
    reset = 1'b0;
    tick(20);
    check("mr_no_strobe", kv_cnt - kv0, 0);
    send_frame(8'h1C, 1'b0, -1);
    check("mr_kv_cnt", kv_cnt - kv0, 1);
    check("mr_next_code", key_code, 8'h1C);
    check("mr_next_rel", key_release, 1'b0);

    check("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
